apb_master_bridge: RTL
======================

Name: apb_master_bridge

Overview:
Upstream APB requester that drives the apb slave's paddr/pwrite/psel/penable/pwdata pins and samples its prdata/pready.
- Converts a simple valid/ready command interface (read or write, one transfer per command) into APB SETUP/ACCESS phases.
- Returns a one-cycle response pulse carrying read data and an error flag.
- A programmable wait-state timeout prevents a stuck pready from hanging the system.

Parameters:
ADDR_W, 8, width of cmd_addr/paddr
DATA_W, 8, width of write/read data
TIMEOUT_CYC, 16, max ACCESS cycles with pready=0 before abort; 0 disables the timeout

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  bridge can accept a command
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  transfer address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  read data (0 for writes/errors)
rsp_err  out  1  transfer aborted by timeout
paddr  out  ADDR_W  APB address
pwrite  out  1  APB direction
psel  out  1  APB select
penable  out  1  APB enable
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB slave ready

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high on port reset. All APB and response outputs are registered.
- Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, wait counter=0. cmd_ready=0 while reset is high.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch write, addr and wdata (pwdata=cmd_wdata for writes, 0 for reads), then go to SETUP.
- SETUP: psel=1, penable=0, cmd_ready=0. Unconditionally go to ACCESS next cycle.
- ACCESS: psel=1, penable=1. paddr, pwrite and pwdata stay stable from SETUP to the end of the transfer.
- Completion, pready=1 in ACCESS:
  - Next cycle: rsp_valid=1, rsp_err=0, rsp_rdata=prdata sampled on that edge for a read, 0 for a write.
  - psel and penable drop to 0; state returns to IDLE.
- Timeout:
  - The wait counter increments on each ACCESS cycle with pready=0.
  - When the counter equals TIMEOUT_CYC (nonzero) and pready=0: abort. Next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0, psel=penable=0, state IDLE.
  - pready=1 on the same cycle the counter hits the limit counts as success, not timeout.
  - Counter clears on entry to SETUP.
- Latency: a command accepted at edge T gives SETUP in cycle T+1 and ACCESS in T+2. Zero-wait completion gives rsp_valid in T+3. Minimum 3 cycles per transfer.
- Response handling: rsp_valid is a single-cycle pulse with no backpressure; the consumer must take it. rsp_rdata and rsp_err hold until the next response.
- Input rules:
  - pready and prdata are ignored outside ACCESS.
  - cmd_* fields are don't-care when cmd_valid=0 or cmd_ready=0.
- Reset asserted mid-transfer: psel and penable drop immediately (asynchronous), no response is issued, and the in-flight command is lost.

Optional Feature:
APB_MASTER_CMD_FIFO_EN
- Defined:
  - Commands pass through a 2-entry FIFO; cmd_ready = !fifo_full in every state, including during a transfer.
  - On completion or abort in ACCESS with the FIFO non-empty, go directly to SETUP. psel stays 1, penable goes to 0, and the new address/data load that cycle.
  - This gives back-to-back transfers at 2 cycles per zero-wait transfer.
  - Push and pop in the same cycle while full is legal.
  - Reset empties the FIFO.
- Undefined: the single-command behaviour above.

Decomposition:
- Package apb_master_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS);
  - a packed command struct {write, addr, wdata}, parameterised via default widths ADDR_W_DEF=8, DATA_W_DEF=8;
  - the FIFO depth constant CMD_FIFO_DEPTH=2.
- Sub-module apb_cmd_fifo: a 2-entry synchronous FIFO of the command struct with full/empty flags. It is instantiated only under APB_MASTER_CMD_FIFO_EN.

Test Plan:
- Write with zero wait states:
  - Stimulus: write addr=0x12, data=0xA5, pready tied to 1.
  - Response: psel=1/penable=0 for 1 cycle, then psel=1/penable=1 for 1 cycle with paddr=0x12, pwrite=1, pwdata=0xA5. rsp_valid at T+3, rsp_err=0. cmd_ready back high at T+3.
- Read with wait states:
  - Stimulus: read addr=0x12; slave holds pready=0 for 3 ACCESS cycles, then pready=1 with prdata=0xA5.
  - Response: penable high for 4 cycles, rsp_rdata=0xA5, rsp_err=0.
- Timeout:
  - Stimulus: TIMEOUT_CYC=4, pready held 0.
  - Response: abort after 4 wait cycles; rsp_valid=1, rsp_err=1, rsp_rdata=0; psel drops; the next command is accepted normally.
- Reset mid-transfer:
  - Stimulus: reset asserted during ACCESS.
  - Response: psel and penable go to 0 asynchronously, no rsp_valid, and after release cmd_ready=1.
- FIFO enabled (APB_MASTER_CMD_FIFO_EN):
  - Stimulus: 3 back-to-back writes to addrs 0x01, 0x02, 0x03, zero-wait slave.
  - Response: transfers complete in 2-cycle cadence with psel never dropping between them; cmd_ready deasserts only when the FIFO holds 2 entries.
- Read after write:
  - Stimulus: write 0x3C to addr 0x07, then read addr 0x07.
  - Response: rsp_rdata=0x3C, and rsp_valid pulses exactly once per command.

Source files
------------

// File: rtl/apb_master_bridge_pkg.sv
// ---------------------------------------------------------------------------
// apb_master_pkg
// Shared types and constants for the APB master bridge.
//   state_t        : bridge FSM states (IDLE, SETUP, ACCESS)
//   cmd_t          : packed command {write, addr, wdata} at the default widths
//   CMD_FIFO_DEPTH : command queue depth used when APB_MASTER_CMD_FIFO_EN is set
// ---------------------------------------------------------------------------
package apb_master_pkg;

  localparam int ADDR_W_DEF     = 8;
  localparam int DATA_W_DEF     = 8;
  localparam int CMD_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// ---------------------------------------------------------------------------
// apb_master_bridge_if
// Bundles the command, response and APB pins of the bridge.
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata : command handshake
//   rsp_valid/rsp_rdata/rsp_err                      : one-cycle response
//   paddr/pwrite/psel/penable/pwdata/prdata/pready   : APB requester pins
// Modports:
//   master : the bridge itself (drives APB pins, cmd_ready and responses)
//   slave  : the environment around it (command source, APB completer)
// ---------------------------------------------------------------------------
interface apb_master_bridge_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  import apb_master_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic              psel;
  logic              penable;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           paddr, pwrite, psel, penable, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           paddr, pwrite, psel, penable, pwdata
  );

endinterface

// File: rtl/apb_master_bridge_cmd_fifo.sv
// ---------------------------------------------------------------------------
// apb_cmd_fifo
// Small synchronous FIFO holding packed bridge commands.
//   clk, reset (async, active-high) : clock / reset, reset empties the queue
//   push, push_data                 : write side (push while full is taken
//                                     only if a pop happens the same cycle)
//   pop, pop_data                   : read side, pop_data shows the head
//   full, empty                     : occupancy flags
// ---------------------------------------------------------------------------
module apb_cmd_fifo
  import apb_master_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int DEPTH = CMD_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A full queue may still accept when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
// Turns single valid/ready commands into APB SETUP/ACCESS transfers and
// returns a one-cycle response with read data and a timeout error flag.
// Ports:
//   clk   : clock, all logic on the rising edge
//   reset : asynchronous, active-high reset
//   bus   : apb_master_bridge_if.master (command, response and APB pins)
// Parameters:
//   ADDR_W, DATA_W : address / data widths
//   TIMEOUT_CYC    : ACCESS wait cycles tolerated before abort, 0 = never
// Build option:
//   APB_MASTER_CMD_FIFO_EN : queue commands in a 2-entry FIFO and chain
//                            transfers back to back (ACCESS -> SETUP).
// ---------------------------------------------------------------------------
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 16
) (
  input logic                  clk,
  input logic                  reset,
  apb_master_bridge_if.master  bus
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);

  // Same layout as cmd_t, sized by this instance's parameters.
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_cmd_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] wait_cnt;
  bus_cmd_t         next_cmd;
  logic             have_cmd;
  logic             load_cmd;
  logic             done_ok;
  logic             done_err;

  assign done_ok  = (state == ACCESS) && bus.pready;
  assign done_err = (state == ACCESS) && !bus.pready && (TIMEOUT_CYC != 0) &&
                    (wait_cnt == CNT_LIMIT);

`ifdef APB_MASTER_CMD_FIFO_EN
  logic     fifo_full;
  logic     fifo_empty;
  bus_cmd_t fifo_out;

  apb_cmd_fifo #(
    .WIDTH ($bits(bus_cmd_t)),
    .DEPTH (CMD_FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.cmd_valid && bus.cmd_ready),
    .push_data ({bus.cmd_write, bus.cmd_addr, bus.cmd_wdata}),
    .pop       (load_cmd),
    .pop_data  (fifo_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign have_cmd = !fifo_empty;
  assign next_cmd = fifo_out;
  // A queued command may start straight out of a finishing ACCESS.
  assign load_cmd = have_cmd && ((state == IDLE) || done_ok || done_err);
`else
  assign have_cmd = bus.cmd_valid;
  assign next_cmd = '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
  assign load_cmd = have_cmd && (state == IDLE) && bus.cmd_ready;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (load_cmd) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (done_ok || done_err) next_state = load_cmd ? SETUP : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode; psel/penable come straight from the state register so
  // they drop the moment reset is asserted.
  always_comb begin
    bus.psel    = (state != IDLE);
    bus.penable = (state == ACCESS);
`ifdef APB_MASTER_CMD_FIFO_EN
    bus.cmd_ready = !reset && !fifo_full;
`else
    bus.cmd_ready = !reset && (state == IDLE);
`endif
  end

  // APB address/data registers, wait counter and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.paddr     <= '0;
      bus.pwrite    <= 1'b0;
      bus.pwdata    <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      // Saturates at the limit; with TIMEOUT_CYC=0 the limit is 0 so it never moves.
      if ((state == ACCESS) && !bus.pready && (wait_cnt != CNT_LIMIT))
        wait_cnt <= wait_cnt + CNT_W'(1);
      if (load_cmd) begin
        bus.paddr  <= next_cmd.addr;
        bus.pwrite <= next_cmd.write;
        bus.pwdata <= next_cmd.write ? next_cmd.wdata : '0;
        wait_cnt   <= '0;
      end
      if (done_ok) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_err   <= 1'b0;
        bus.rsp_rdata <= bus.pwrite ? '0 : bus.prdata;
      end else if (done_err) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_err   <= 1'b1;
        bus.rsp_rdata <= '0;
      end
    end
  end

endmodule
